// File: rtl/eh2_ccm_mem_arb.sv
// Banked CCM SRAM shared by NUM_CH requesters, with an independent round-robin arbiter per bank.
// Define EH2_CCM_MEM_ZERO_INIT_EN to zero every row during INIT (BANK_DEPTH cycles) before entering RUN.
module eh2_ccm_mem_arb #(
   parameter int NUM_CH     = 4,
   parameter int NUM_BANKS  = 4,
   parameter int BANK_DEPTH = 256,
   parameter int DATA_W     = 32,
   localparam int ADDR_W    = $clog2(NUM_BANKS * BANK_DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        req_valid,
   input  logic [NUM_CH-1:0]        req_we,
   input  logic [NUM_CH*ADDR_W-1:0] req_addr,
   input  logic [NUM_CH*DATA_W-1:0] req_wdata,
   output logic [NUM_CH-1:0]        req_ready,
   output logic [NUM_CH-1:0]        rsp_valid,
   output logic [NUM_CH*DATA_W-1:0] rsp_rdata,
   output logic                     init_done,
   output logic [15:0]              stall_cnt
);

   localparam int LOG_NB = $clog2(NUM_BANKS);
   localparam int BK_W   = (LOG_NB > 0) ? LOG_NB : 1;
   localparam int ROW_W  = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic {INIT, RUN} state_t;

   function automatic logic [BK_W-1:0] bank_of(input logic [ADDR_W-1:0] a);
      return BK_W'(a % NUM_BANKS);
   endfunction

   function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_W-1:0] a);
      return ROW_W'(a >> LOG_NB);
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   state_t              state_q;
   logic [CH_W-1:0]     ptr_q      [NUM_BANKS];
   logic [NUM_CH-1:0]   rsp_valid_q;
   logic [BK_W-1:0]     rsp_bank_q [NUM_CH];
   logic [15:0]         stall_q;
`ifdef EH2_CCM_MEM_ZERO_INIT_EN
   logic [ROW_W-1:0]    init_row_q;
`endif

   logic [DATA_W-1:0]   mem_q      [NUM_BANKS][BANK_DEPTH];
   logic [DATA_W-1:0]   rd_q       [NUM_BANKS];

   logic [ADDR_W-1:0]   ch_addr    [NUM_CH];
   logic [DATA_W-1:0]   ch_wdata   [NUM_CH];
   logic [BK_W-1:0]     ch_bank    [NUM_CH];
   logic [NUM_BANKS-1:0] bank_vld;
   logic [CH_W-1:0]     bank_ch    [NUM_BANKS];
   logic [NUM_BANKS-1:0] bank_we;
   logic [NUM_BANKS-1:0] bank_re;
   logic [ROW_W-1:0]    bank_row   [NUM_BANKS];
   logic [DATA_W-1:0]   bank_wd    [NUM_BANKS];
   logic [NUM_CH-1:0]   gnt;

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         ch_addr[c]  = req_addr[c*ADDR_W +: ADDR_W];
         ch_wdata[c] = req_wdata[c*DATA_W +: DATA_W];
         ch_bank[c]  = bank_of(ch_addr[c]);
      end
   end

   // Per bank: scan channels starting at the pointer, first valid requester of this bank wins
   always_comb begin
      int c;
      c        = 0;
      bank_vld = '0;
      gnt      = '0;
      bank_we  = '0;
      bank_re  = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         bank_ch[b]  = '0;
         bank_row[b] = '0;
         bank_wd[b]  = '0;
         for (int k = 0; k < NUM_CH; k++) begin
            c = (int'(ptr_q[b]) + k) % NUM_CH;
            if (state_q == RUN && !bank_vld[b] && req_valid[c] && int'(ch_bank[c]) == b) begin
               bank_vld[b] = 1'b1;
               bank_ch[b]  = CH_W'(c);
            end
         end
         if (bank_vld[b]) begin
            gnt[bank_ch[b]] = 1'b1;
            bank_we[b]      = req_we[bank_ch[b]];
            bank_re[b]      = ~req_we[bank_ch[b]];
            bank_row[b]     = row_of(ch_addr[bank_ch[b]]);
            bank_wd[b]      = ch_wdata[bank_ch[b]];
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
`ifdef EH2_CCM_MEM_ZERO_INIT_EN
         if (state_q == INIT) mem_q[b][init_row_q] <= '0;
         else if (bank_we[b]) mem_q[b][bank_row[b]] <= bank_wd[b];
`else
         if (bank_we[b]) mem_q[b][bank_row[b]] <= bank_wd[b];
`endif
         if (bank_re[b]) rd_q[b] <= mem_q[b][bank_row[b]];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= INIT;
         rsp_valid_q <= '0;
         stall_q     <= '0;
`ifdef EH2_CCM_MEM_ZERO_INIT_EN
         init_row_q  <= '0;
`endif
         for (int b = 0; b < NUM_BANKS; b++) ptr_q[b] <= '0;
         for (int c = 0; c < NUM_CH; c++) rsp_bank_q[c] <= '0;
      end else begin
         case (state_q)
            INIT: begin
`ifdef EH2_CCM_MEM_ZERO_INIT_EN
               if (init_row_q == ROW_W'(BANK_DEPTH - 1)) state_q <= RUN;
               else init_row_q <= init_row_q + 1'b1;
`else
               state_q <= RUN;
`endif
            end
            RUN: begin
               for (int b = 0; b < NUM_BANKS; b++)
                  if (bank_vld[b]) ptr_q[b] <= CH_W'((int'(bank_ch[b]) + 1) % NUM_CH);
               if (|(req_valid & ~gnt)) stall_q <= sat_inc16(stall_q);
            end
         endcase
         rsp_valid_q <= gnt & ~req_we;
         for (int c = 0; c < NUM_CH; c++) rsp_bank_q[c] <= ch_bank[c];
      end
   end

   always_comb begin
      rsp_rdata = '0;
      for (int c = 0; c < NUM_CH; c++)
         if (rsp_valid_q[c]) rsp_rdata[c*DATA_W +: DATA_W] = rd_q[rsp_bank_q[c]];
   end

   assign req_ready = gnt;
   assign rsp_valid = rsp_valid_q;
   assign init_done = (state_q == RUN);
   assign stall_cnt = stall_q;

endmodule
